// File: rtl/jtframe_neptuno_segajoy.sv
// Sega 3/6-button DB9 scan sequencer for both Neptuno joystick ports.
// Define JTFRAME_SEGA6_EN for the 8-phase 6-button scan; otherwise phases 0..3 only.
module jtframe_neptuno_segajoy #(
  parameter int unsigned CLK_KHZ    = 48000,
  parameter int unsigned STEP_US    = 10,
  parameter int unsigned IDLE_STEPS = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [5:0]  joy1_bus,
  input  logic [5:0]  joy2_bus,
  output logic        joy_select,
  output logic [11:0] joy1,
  output logic [11:0] joy2,
  output logic [1:0]  pad6,
  output logic        valid
);

  localparam int unsigned STEP_CYC = CLK_KHZ * STEP_US / 1000;
  localparam int unsigned CNT_W    = $clog2(STEP_CYC + 1);
  localparam int unsigned IDLE_W   = $clog2(IDLE_STEPS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STEP_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_STEPS - 1);

  typedef enum logic [2:0] {
    PH0 = 3'd0, PH1 = 3'd1, PH2 = 3'd2, PH3 = 3'd3,
    PH4 = 3'd4, PH5 = 3'd5, PH6 = 3'd6, PH7 = 3'd7
  } phase_t;

`ifdef JTFRAME_SEGA6_EN
  localparam phase_t PH_LAST = PH7;
`else
  localparam phase_t PH_LAST = PH3;
`endif

  typedef struct packed {
    logic [3:0] dpad;     // {up, down, left, right} in output-word order
    logic       a;
    logic       b;
    logic       c;
    logic       st;
    logic       present;
`ifdef JTFRAME_SEGA6_EN
    logic       six;
    logic [3:0] xyzm;     // {mode, z, y, x} in output-word order
`endif
  } shadow_t;

  // Bus synchronizers
  logic [5:0] j1_meta_q, j1_sync_q, j2_meta_q, j2_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j1_meta_q <= '1;
      j1_sync_q <= '1;
      j2_meta_q <= '1;
      j2_sync_q <= '1;
    end else begin
      j1_meta_q <= joy1_bus;
      j1_sync_q <= j1_meta_q;
      j2_meta_q <= joy2_bus;
      j2_sync_q <= j2_meta_q;
    end
  end

  logic [1:0][5:0] bus_s;
  assign bus_s[0] = j1_sync_q;
  assign bus_s[1] = j2_sync_q;

  // Prescaler, idle counter and phase state
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  phase_t            ph_q, ph_d;
  logic              tick, last_idle, start, commit;

  assign tick      = (cnt_q == CNT_LAST);
  assign last_idle = (ph_q == PH0) && tick && (idle_q == IDLE_LAST);
  assign start     = last_idle && en;
  assign commit    = (ph_q == PH_LAST) && tick;

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idle_d = idle_q;
    ph_d   = ph_q;
    case (ph_q)
      PH0: begin
        if (tick) idle_d = last_idle ? '0 : idle_q + 1'b1;
        if (start) ph_d = PH1;
      end
      default: begin
        if (tick) ph_d = (ph_q == PH_LAST) ? PH0 : phase_t'(ph_q + 3'd1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idle_q <= '0;
      ph_q   <= PH0;
    end else begin
      cnt_q  <= cnt_d;
      idle_q <= idle_d;
      ph_q   <= ph_d;
    end
  end

  // Select is a pure decode of the phase register so reset forces it high at once
  assign joy_select = ~ph_q[0];

  // Shadow capture
  shadow_t [1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    for (int unsigned p = 0; p < 2; p++) begin
      if (tick) begin
        case (ph_q)
          PH0: if (start) begin
            sh_d[p].dpad = ~{bus_s[p][0], bus_s[p][1], bus_s[p][2], bus_s[p][3]};
            sh_d[p].b    = ~bus_s[p][4];
            sh_d[p].c    = ~bus_s[p][5];
          end
          PH1: begin
            sh_d[p].present = (bus_s[p][3:2] == 2'b00);
            sh_d[p].a       = ~bus_s[p][4];
            sh_d[p].st      = ~bus_s[p][5];
          end
`ifdef JTFRAME_SEGA6_EN
          PH5: sh_d[p].six  = (bus_s[p][3:0] == 4'b0000);
          PH6: sh_d[p].xyzm = ~{bus_s[p][3], bus_s[p][0], bus_s[p][1], bus_s[p][2]};
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= sh_d;
  end

  function automatic logic [11:0] word_of(input shadow_t s);
    logic [11:0] w;
    w = '0;
    if (s.present) begin
      w[7:0] = {s.st, s.c, s.b, s.a, s.dpad};
`ifdef JTFRAME_SEGA6_EN
      if (s.six) w[11:8] = s.xyzm;
`endif
    end
    return w;
  endfunction

  function automatic logic is_six(input shadow_t s);
`ifdef JTFRAME_SEGA6_EN
    return s.present & s.six;
`else
    return 1'b0 & s.present;
`endif
  endfunction

  // Committed outputs
  logic [11:0] joy1_q, joy2_q;
  logic [1:0]  pad6_q;
  logic        valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      joy1_q  <= '0;
      joy2_q  <= '0;
      pad6_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= commit;
      if (commit) begin
        joy1_q <= word_of(sh_q[0]);
        joy2_q <= word_of(sh_q[1]);
        pad6_q <= {is_six(sh_q[1]), is_six(sh_q[0])};
      end
    end
  end

  assign joy1  = joy1_q;
  assign joy2  = joy2_q;
  assign pad6  = pad6_q;
  assign valid = valid_q;

endmodule
